// File: rtl/branch_flow_controller.sv
// branch_flow_controller: decode-stage control-flow sequencer.
// Holds conditional branches until all in-flight flag writers have retired.
// On a taken branch it issues a single-cycle PC redirect and then a fetch
// flush of fixed length.
// Handshake: stall_decode is a hold request to decode/fetch. While it is
// high, the instruction in decode must stay put. redirect_pc is a one-cycle
// strobe with no back-pressure. flush_fetch is a level that invalidates
// fetch/decode for as long as it is high.
module branch_flow_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PEND_WIDTH   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  decode_valid,
  input  logic [31:0]           decode_operation,
  input  logic                  take_branch_target,
  input  logic                  flag_writer_issue,
  input  logic                  flag_writer_retire,
  output logic                  stall_decode,
  output logic                  redirect_pc,
  output logic                  flush_fetch,
  output logic [PEND_WIDTH-1:0] pending_flag_writers,
  output logic                  pending_overflow,
  output logic [15:0]           taken_count,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    REDIRECT   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  // Flush cycles are counted including the redirect cycle, so the last
  // FLUSH cycle is reached when the counter equals FLUSH_CYCLES-1.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            flush_cnt_q, flush_cnt_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           taken_q, taken_d;

  logic is_branch, is_cond, pend_zero, pend_max;
  logic unused_op_bits;

  assign is_branch = decode_valid &&
                     (decode_operation[7:0] == 8'h38 || decode_operation[7:0] == 8'h42);
  assign is_cond   = decode_valid && decode_operation[7:0] == 8'h38 &&
                     decode_operation[9:8] != 2'b00;
  assign pend_zero = (pend_q == '0);
  assign pend_max  = &pend_q;
  assign unused_op_bits = ^decode_operation[31:10];

  // In-flight flag-writer counter. It saturates at both ends, and an issue
  // that arrives while the counter is full sets the sticky overflow flag.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (flag_writer_issue && !flag_writer_retire) begin
      if (pend_max) ovf_d = 1'b1;
      else          pend_d = pend_q + PEND_WIDTH'(1);
    end else if (flag_writer_retire && !flag_writer_issue && !pend_zero) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

  // Next-state and output decode for the branch sequencer.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    taken_d      = taken_q;
    stall_decode = 1'b0;
    redirect_pc  = 1'b0;
    flush_fetch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_cond && !pend_zero) begin
          stall_decode = 1'b1;
          state_d      = WAIT_FLAGS;
        end else if (is_branch && take_branch_target) begin
          state_d = REDIRECT;
        end
      end
      WAIT_FLAGS: begin
        stall_decode = 1'b1;
        if (!decode_valid) begin
          state_d = IDLE;
        end else if (pend_zero) begin
          // The flags are current in this cycle, so the resolution result is final.
          state_d = take_branch_target ? REDIRECT : IDLE;
        end
      end
      REDIRECT: begin
        redirect_pc = 1'b1;
        flush_fetch = 1'b1;
        taken_d     = taken_q + 16'd1;
        flush_cnt_d = 4'd1;
        state_d     = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush_fetch = 1'b1;
        if (flush_cnt_q >= FLUSH_LAST) state_d = IDLE;
        else                           flush_cnt_d = flush_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      taken_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      taken_q     <= taken_d;
    end
  end

  assign pending_flag_writers = pend_q;
  assign pending_overflow     = ovf_q;
  assign taken_count          = taken_q;
  assign fsm_state            = state_q;

endmodule

// File: tb/tb_branch_flow_controller.sv
// tb_branch_flow_controller: directed and random stimulus for the branch sequencer.
module tb_branch_flow_controller;
  localparam int FC = 4;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          decode_valid;
  logic [31:0]   decode_operation;
  logic          take_branch_target;
  logic          flag_writer_issue;
  logic          flag_writer_retire;
  logic          stall_decode;
  logic          redirect_pc;
  logic          flush_fetch;
  logic [PW-1:0] pending_flag_writers;
  logic          pending_overflow;
  logic [15:0]   taken_count;
  logic [1:0]    fsm_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_taken = 0;
  logic [31:0] exp_q[$];

  branch_flow_controller #(.FLUSH_CYCLES(FC), .PEND_WIDTH(PW)) dut (
    .clock(clock), .reset(reset),
    .decode_valid(decode_valid), .decode_operation(decode_operation),
    .take_branch_target(take_branch_target),
    .flag_writer_issue(flag_writer_issue), .flag_writer_retire(flag_writer_retire),
    .stall_decode(stall_decode), .redirect_pc(redirect_pc), .flush_fetch(flush_fetch),
    .pending_flag_writers(pending_flag_writers), .pending_overflow(pending_overflow),
    .taken_count(taken_count), .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic drive_idle();
    decode_valid       = 1'b0;
    decode_operation   = 32'h0;
    take_branch_target = 1'b0;
    flag_writer_issue  = 1'b0;
    flag_writer_retire = 1'b0;
  endtask

  task automatic issue_n(input int n);
    flag_writer_issue = 1'b1;
    repeat (n) tick();
    flag_writer_issue = 1'b0;
  endtask

  task automatic retire_n(input int n);
    flag_writer_retire = 1'b1;
    repeat (n) tick();
    flag_writer_retire = 1'b0;
  endtask

  // Scoreboard: every redirect pulse is checked against the cycle queued by the driver
  always @(negedge clock) begin
    if (!reset) begin
      if (redirect_pc) begin
        if (exp_q.size() == 0) check_eq("unexpected_redirect", cyc, 32'hFFFF_FFFF);
        else                   check_eq("redirect_cycle", cyc, exp_q.pop_front());
      end
      if (stall_decode && redirect_pc) check_eq("stall_redirect_excl", 32'd1, 32'd0);
    end
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    sample();
    check_eq("rst_stall", stall_decode, 0);
    check_eq("rst_redirect", redirect_pc, 0);
    check_eq("rst_flush", flush_fetch, 0);
    check_eq("rst_pending", pending_flag_writers, 0);
    check_eq("rst_ovf", pending_overflow, 0);
    check_eq("rst_taken", taken_count, 0);
    check_eq("rst_state", fsm_state, 0);

    // Unconditional branch 0x42 with no writers in flight
    tick();
    decode_valid = 1'b1; decode_operation = 32'h0000_0042; take_branch_target = 1'b1;
    exp_q.push_back(cyc + 1);
    sample();
    check_eq("t1_stall_n", stall_decode, 0);
    tick();
    drive_idle();
    for (int k = 1; k <= FC + 1; k++) begin
      sample();
      check_eq("t1_flush", flush_fetch, (k <= FC) ? 32'd1 : 32'd0);
      check_eq("t1_stall", stall_decode, 0);
      tick();
    end
    exp_taken++;
    check_eq("t1_taken", taken_count, exp_taken);

    // Conditional branch waits for two writers, then is taken
    issue_n(2);
    check_eq("t2_pending2", pending_flag_writers, 2);
    decode_valid = 1'b1; decode_operation = 32'h0000_0538; take_branch_target = 1'b1;
    sample();
    check_eq("t2_stall_idle", stall_decode, 1);
    tick();
    check_eq("t2_state_wait", fsm_state, 1);
    flag_writer_retire = 1'b1;
    tick();
    sample();
    check_eq("t2_stall_after_r1", stall_decode, 1);
    exp_q.push_back(cyc + 2);
    tick();
    flag_writer_retire = 1'b0;
    sample();
    check_eq("t2_pending0", pending_flag_writers, 0);
    check_eq("t2_stall_eval", stall_decode, 1);
    tick();
    drive_idle();
    sample();
    check_eq("t2_stall_redirect", stall_decode, 0);
    check_eq("t2_redirect", redirect_pc, 1);
    repeat (FC) tick();
    exp_taken++;
    check_eq("t2_taken", taken_count, exp_taken);

    // Conditional branch resolves not taken
    issue_n(2);
    decode_valid = 1'b1; decode_operation = 32'h0000_0538; take_branch_target = 1'b0;
    tick();
    retire_n(2);
    sample();
    check_eq("t3_stall_eval", stall_decode, 1);
    tick();
    decode_valid = 1'b0;
    sample();
    check_eq("t3_state_idle", fsm_state, 0);
    check_eq("t3_flush", flush_fetch, 0);
    check_eq("t3_stall", stall_decode, 0);
    tick(); tick();
    check_eq("t3_taken", taken_count, exp_taken);

    // Killed while waiting, plus simultaneous issue and retire at pending 3
    issue_n(3);
    decode_valid = 1'b1; decode_operation = 32'h0000_0538; take_branch_target = 1'b1;
    tick();
    check_eq("t4_state_wait", fsm_state, 1);
    decode_valid = 1'b0;
    flag_writer_issue = 1'b1; flag_writer_retire = 1'b1;
    tick();
    flag_writer_issue = 1'b0; flag_writer_retire = 1'b0;
    sample();
    check_eq("t4_state_idle", fsm_state, 0);
    check_eq("t4_pending_hold", pending_flag_writers, 3);
    check_eq("t4_stall", stall_decode, 0);
    tick();
    retire_n(3);
    check_eq("t4_pending0", pending_flag_writers, 0);

    // Saturation and sticky overflow
    issue_n(7);
    check_eq("t5_pending7", pending_flag_writers, 7);
    check_eq("t5_ovf_before", pending_overflow, 0);
    issue_n(1);
    check_eq("t5_pending_sat", pending_flag_writers, 7);
    check_eq("t5_ovf_set", pending_overflow, 1);
    retire_n(8);
    check_eq("t5_pending_floor", pending_flag_writers, 0);
    check_eq("t5_ovf_sticky", pending_overflow, 1);

    // Random unconditional branches (0x42 or 0x38 with cond 00), random outcome
    for (int i = 0; i < 8; i++) begin
      decode_valid = 1'b1;
      decode_operation = ($urandom_range(0, 1) == 1) ? 32'h0000_0042 : 32'h0000_0038;
      take_branch_target = 1'($urandom_range(0, 1));
      if (take_branch_target) begin
        exp_q.push_back(cyc + 1);
        exp_taken++;
      end
      sample();
      check_eq("rnd_stall", stall_decode, 0);
      tick();
      drive_idle();
      repeat (FC + 1) tick();
    end
    check_eq("rnd_taken", taken_count, exp_taken);

    // Reset during the second flush cycle
    decode_valid = 1'b1; decode_operation = 32'h0000_0042; take_branch_target = 1'b1;
    exp_q.push_back(cyc + 1);
    tick();
    drive_idle();
    tick(); tick();
    sample();
    check_eq("t6_flush_before", flush_fetch, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check_eq("t6_flush_cut", flush_fetch, 0);
    check_eq("t6_state", fsm_state, 0);
    check_eq("t6_taken", taken_count, 0);
    check_eq("t6_ovf", pending_overflow, 0);
    check_eq("t6_pending", pending_flag_writers, 0);
    tick(); tick();

    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_flow_controller.md
Name: branch_flow_controller

Overview:
- Sequences control-flow changes in the decode stage.
- Watches the instruction held in decode together with the combinational take_branch_target from branch resolution logic.
- Tracks in-flight flag-writing instructions and stalls decode on conditional branches until flags are architecturally current.
- On a taken branch, issues a one-cycle PC redirect and a fixed-length fetch flush.

Parameters:
FLUSH_CYCLES, 2, cycles flush_fetch is high per taken branch (includes the redirect cycle); legal range 1..15
PEND_WIDTH, 3, width of the in-flight flag-writer counter

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
decode_valid  input  1  decode_operation holds a live instruction
decode_operation  input  32  instruction in decode
take_branch_target  input  1  resolution result for decode_operation against current flags (combinational, same cycle)
flag_writer_issue  input  1  a flag-setting instruction leaves decode this cycle
flag_writer_retire  input  1  a flag-setting instruction writes the flags this cycle
stall_decode  output  1  hold decode and fetch
redirect_pc  output  1  one-cycle pulse; fetch loads the branch target
flush_fetch  output  1  invalidate fetch/decode pipeline registers
pending_flag_writers  output  PEND_WIDTH  in-flight flag-writer count
pending_overflow  output  1  sticky; an issue arrived with the counter at maximum
taken_count  output  16  number of taken branches; wraps at 16'hFFFF -> 0

Behaviour:
- Decode:
  - is_branch = decode_valid & (op[7:0]==8'h38 | op[7:0]==8'h42).
  - is_cond = decode_valid & op[7:0]==8'h38 & op[9:8]!=2'b00.
  - Unconditional branches (8'h38 with cond 00, and 8'h42) never wait on flags.
- States: IDLE, WAIT_FLAGS, REDIRECT, FLUSH. Reset -> IDLE.
- IDLE:
  - is_cond & pending!=0 -> WAIT_FLAGS. stall_decode=1 combinationally in this same cycle.
  - Otherwise, is_branch & take_branch_target -> REDIRECT next cycle.
  - Otherwise, a branch with take_branch_target low (not taken) -> stay IDLE; all outputs low.
- WAIT_FLAGS:
  - stall_decode=1.
  - decode_valid=0 -> IDLE (instruction killed); no redirect.
  - pending==0 -> evaluate take_branch_target in this cycle: taken -> REDIRECT, else -> IDLE. stall_decode stays 1 in this cycle and drops next cycle.
- REDIRECT:
  - Lasts exactly 1 cycle.
  - redirect_pc=1, flush_fetch=1, stall_decode=0.
  - taken_count increments by 1.
  - Next state: FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH:
  - flush_fetch=1; an internal counter keeps the total flush_fetch duration at FLUSH_CYCLES, then -> IDLE.
  - Branches seen in decode during REDIRECT/FLUSH are ignored; they are being flushed.
- Latency:
  - Branch in decode at cycle N with no stall -> redirect_pc at N+1.
  - flush_fetch high N+1 .. N+FLUSH_CYCLES.
- pending counter:
  - issue only -> +1.
  - retire only -> -1.
  - issue and retire in the same cycle -> unchanged.
  - issue at all-ones -> count holds, pending_overflow set (sticky until reset).
  - retire at 0 -> holds at 0.
  - The counter updates in every state, including during stall and flush.
- Flags written by a retiring writer are visible to take_branch_target in the cycle after retire, the same cycle pending reaches 0.
- Reset asserted in any state:
  - Next cycle: IDLE, all outputs 0, counters 0, pending_overflow 0.
  - An in-progress redirect or flush is abandoned.
- stall_decode, redirect_pc and flush_fetch are never undefined. stall_decode and redirect_pc are mutually exclusive.

Test Plan:
- Reset, then op=32'h00000042 valid, pending=0 -> redirect_pc pulse at N+1; flush_fetch high N+1..N+2; taken_count=1; stall_decode never high.
- 2 issue pulses, then op=32'h00000538 (zero-set branch) valid -> stall_decode high; 1 retire keeps stall; 2nd retire at cycle R -> evaluate at R+1 with take_branch_target=1 -> redirect_pc at R+2; stall_decode low from R+2.
- Same setup with take_branch_target=0 at evaluation -> returns to IDLE; no redirect_pc or flush_fetch; taken_count unchanged.
- While in WAIT_FLAGS, drop decode_valid -> IDLE next cycle; no redirect. Simultaneous issue+retire with pending=3 -> pending stays 3.
- 8 issue pulses with PEND_WIDTH=3 -> pending=7, pending_overflow=1; 8 retires -> pending=0, overflow stays 1.
- Assert reset during FLUSH (FLUSH_CYCLES=4, 2nd flush cycle) -> flush_fetch low next cycle; state IDLE; taken_count=0.
